// File: rtl/usb_tx_handshake_encoder.sv
// rtl/usb_tx_handshake_encoder.sv - full-speed USB ACK/NAK/DATA0 transmitter with bit stuffing and NRZI
// Optional DATA0 CRC16 trailer enabled by defining TX_CRC16_EN.
module usb_tx_handshake_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       transmit_ack,
    input  logic       transmit_nack,
    input  logic       host_ready,
    input  logic [7:0] tx_data,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy
);
    localparam int               DIV_W     = $clog2(2 * CLKS_PER_BIT) + 1;
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] BIT_END   = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] SE0_END   = DIV_W'(2 * CLKS_PER_BIT - 1);
    localparam logic [7:0]       SYNC      = 8'h80;
    localparam logic [7:0]       PID_ACK   = 8'hD2;
    localparam logic [7:0]       PID_NAK   = 8'h5A;
    localparam logic [7:0]       PID_DATA0 = 8'hC3;
    localparam logic [5:0]       HS_LEN    = 6'd16;
`ifdef TX_CRC16_EN
    localparam logic [5:0]       DATA_LEN  = 6'd40;
`else
    localparam logic [5:0]       DATA_LEN  = 6'd24;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SHIFT, S_STUFF, S_EOP_SE0, S_EOP_J
    } state_t;

    state_t           r_state;
    logic             r_pend_ack;
    logic             r_pend_nack;
    logic             r_pend_data;
    logic [7:0]       r_data;
    logic [23:0]      r_shift;
    logic [5:0]       r_bit_idx;
    logic [5:0]       r_len;
    logic [2:0]       r_ones;
    logic [DIV_W-1:0] r_div;
    logic             r_level;
    logic             r_cur_bit;
    logic             r_dp;
    logic             r_dm;
    logic             r_busy;
`ifdef TX_CRC16_EN
    logic [15:0]      r_crc;
    logic [15:0]      w_crc_next;
`endif

    logic       w_bit;
    logic       w_level_next;
    logic [2:0] w_ones_next;
    logic       w_last;
    logic       w_bit_end;
    logic       w_stuff;
    logic       w_advance;

    // r_bit_idx counts bits already driven, so it also selects the next list bit
    always_comb begin
        w_bit = r_shift[0];
`ifdef TX_CRC16_EN
        if (r_bit_idx >= 6'd24)
            w_bit = ~r_crc[0];
`endif
    end

`ifdef TX_CRC16_EN
    always_comb begin
        w_crc_next = r_crc;
        if (r_bit_idx >= 6'd16 && r_bit_idx < 6'd24)
            w_crc_next = {1'b0, r_crc[15:1]} ^ ((r_crc[0] ^ w_bit) ? 16'hA001 : 16'h0000);
        else if (r_bit_idx >= 6'd24)
            w_crc_next = {1'b0, r_crc[15:1]};
    end
`endif

    assign w_level_next = w_bit ? r_level : ~r_level;
    assign w_ones_next  = r_cur_bit ? r_ones + 3'd1 : 3'd0;
    assign w_last       = (r_bit_idx == r_len);
    assign w_bit_end    = (r_div == BIT_END);
    assign w_stuff      = (w_ones_next == 3'd6);
    assign w_advance    = (r_state == S_LOAD)
                       || (r_state == S_SHIFT && w_bit_end && !w_stuff && !w_last)
                       || (r_state == S_STUFF && w_bit_end && !w_last);

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state     <= S_IDLE;
            r_pend_ack  <= 1'b0;
            r_pend_nack <= 1'b0;
            r_pend_data <= 1'b0;
            r_data      <= '0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_len       <= '0;
            r_ones      <= '0;
            r_div       <= '0;
            r_level     <= 1'b1;
            r_cur_bit   <= 1'b0;
            r_dp        <= 1'b1;
            r_dm        <= 1'b0;
            r_busy      <= 1'b0;
`ifdef TX_CRC16_EN
            r_crc       <= 16'hFFFF;
`endif
        end else begin
            if (transmit_ack)
                r_pend_ack <= 1'b1;
            if (transmit_nack)
                r_pend_nack <= 1'b1;
            if (host_ready && !r_pend_data) begin
                r_pend_data <= 1'b1;
                r_data      <= tx_data;
            end
            r_div <= r_div + DIV_ONE;
            case (r_state)
                S_IDLE: begin
                    r_div     <= '0;
                    r_bit_idx <= '0;
                    r_ones    <= '0;
                    r_level   <= 1'b1;
`ifdef TX_CRC16_EN
                    r_crc     <= 16'hFFFF;
`endif
                    if (r_pend_nack) begin
                        r_pend_nack <= 1'b0;
                        r_shift     <= {8'h00, PID_NAK, SYNC};
                        r_len       <= HS_LEN;
                        r_state     <= S_LOAD;
                    end else if (r_pend_ack) begin
                        r_pend_ack <= 1'b0;
                        r_shift    <= {8'h00, PID_ACK, SYNC};
                        r_len      <= HS_LEN;
                        r_state    <= S_LOAD;
                    end else if (r_pend_data) begin
                        r_pend_data <= 1'b0;
                        r_shift     <= {r_data, PID_DATA0, SYNC};
                        r_len       <= DATA_LEN;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_busy  <= 1'b1;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (w_bit_end) begin
                        r_ones <= w_ones_next;
                        // the stuff check precedes the end check so a trailing stuff still goes out
                        if (w_stuff) begin
                            r_state <= S_STUFF;
                            r_ones  <= '0;
                            r_level <= ~r_level;
                            r_dp    <= ~r_level;
                            r_dm    <= r_level;
                            r_div   <= '0;
                        end else if (w_last) begin
                            r_state <= S_EOP_SE0;
                            r_dp    <= 1'b0;
                            r_dm    <= 1'b0;
                            r_div   <= '0;
                        end
                    end
                end
                S_STUFF: begin
                    if (w_bit_end) begin
                        if (w_last) begin
                            r_state <= S_EOP_SE0;
                            r_dp    <= 1'b0;
                            r_dm    <= 1'b0;
                            r_div   <= '0;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_EOP_SE0: begin
                    if (r_div == SE0_END) begin
                        r_state <= S_EOP_J;
                        r_dp    <= 1'b1;
                        r_dm    <= 1'b0;
                        r_level <= 1'b1;
                        r_div   <= '0;
                    end
                end
                S_EOP_J: begin
                    if (w_bit_end) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_div   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_advance) begin
                r_dp      <= w_level_next;
                r_dm      <= ~w_level_next;
                r_level   <= w_level_next;
                r_cur_bit <= w_bit;
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + 6'd1;
                r_div     <= '0;
`ifdef TX_CRC16_EN
                r_crc     <= w_crc_next;
`endif
            end
        end
    end

    assign d_plus  = r_dp;
    assign d_minus = r_dm;
    assign tx_busy = r_busy;

endmodule

// File: tb/tb_usb_tx_handshake_encoder.sv
// tb/tb_usb_tx_handshake_encoder.sv - self-checking bench for usb_tx_handshake_encoder
// Two instances (CLKS_PER_BIT 4 and 1); samples are {tx_busy, d_plus, d_minus} taken at negedge.
module tb_usb_tx_handshake_encoder;
    localparam logic [2:0] IDLE_J   = 3'b010;
    localparam logic [2:0] BUSY_J   = 3'b110;
    localparam logic [2:0] BUSY_K   = 3'b101;
    localparam logic [2:0] BUSY_SE0 = 3'b100;
`ifdef TX_CRC16_EN
    localparam int BUSY_FF  = 45;
    localparam int BUSY_ALL = 83;
    localparam int NBITS_FF = 40;
    localparam int STUFF_FF = 2;
`else
    localparam int BUSY_FF  = 28;
    localparam int BUSY_ALL = 66;
    localparam int NBITS_FF = 24;
    localparam int STUFF_FF = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4 = 1'b1, ack4 = 1'b0, nack4 = 1'b0, hr4 = 1'b0;
    logic [7:0] data4 = 8'h00;
    logic       dp4, dm4, busy4;
    logic       rst1 = 1'b1, ack1 = 1'b0, nack1 = 1'b0, hr1 = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic       dp1, dm1, busy1;

    usb_tx_handshake_encoder #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .n_rst(rst4), .transmit_ack(ack4), .transmit_nack(nack4),
        .host_ready(hr4), .tx_data(data4), .d_plus(dp4), .d_minus(dm4), .tx_busy(busy4)
    );
    usb_tx_handshake_encoder #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .n_rst(rst1), .transmit_ack(ack1), .transmit_nack(nack1),
        .host_ready(hr1), .tx_data(data1), .d_plus(dp1), .d_minus(dm1), .tx_busy(busy1)
    );

    int total = 0;
    int bad   = 0;
    logic [2:0] cap[$];
    logic [2:0] exp_q[$];

    typedef struct {
        int         cpb;
        bit         a;
        bit         n;
        bit         h;
        logic [7:0] d;
        int         exp_busy;
        int         exp_pkts;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

`ifdef TX_CRC16_EN
    function automatic logic [15:0] crc16_model(input logic [7:0] d);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < 8; i++)
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return ~c;
    endfunction
`endif

    task automatic push_sym(input int cpb, input bit b, inout bit lvl_j);
        if (!b) lvl_j = !lvl_j;
        repeat (cpb) exp_q.push_back(lvl_j ? BUSY_J : BUSY_K);
    endtask

    // One packet: LOAD cycle, bit list with stuffing and NRZI, 2 bit times SE0, 1 bit time J
    task automatic add_packet(input int cpb, input logic [7:0] pid, input bit has_data, input logic [7:0] d);
        bit bits[$];
        bit lvl_j = 1'b1;
        int ones = 0;
`ifdef TX_CRC16_EN
        logic [15:0] crc;
`endif
        for (int i = 0; i < 8; i++) bits.push_back(i == 7);
        for (int i = 0; i < 8; i++) bits.push_back(pid[i]);
        if (has_data) begin
            for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef TX_CRC16_EN
            crc = crc16_model(d);
            for (int i = 0; i < 16; i++) bits.push_back(crc[i]);
`endif
        end
        exp_q.push_back(IDLE_J);
        foreach (bits[i]) begin
            push_sym(cpb, bits[i], lvl_j);
            ones = bits[i] ? ones + 1 : 0;
            if (ones == 6) begin
                push_sym(cpb, 1'b0, lvl_j);
                ones = 0;
            end
        end
        repeat (2 * cpb) exp_q.push_back(BUSY_SE0);
        repeat (cpb) exp_q.push_back(BUSY_J);
    endtask

    task automatic build_expected(input int cpb, input bit a, input bit n, input bit h, input logic [7:0] d);
        bit first = 1'b1;
        exp_q.delete();
        if (n) begin
            add_packet(cpb, 8'h5A, 1'b0, 8'h00);
            first = 1'b0;
        end
        if (a) begin
            if (!first) exp_q.push_back(IDLE_J);
            add_packet(cpb, 8'hD2, 1'b0, 8'h00);
            first = 1'b0;
        end
        if (h) begin
            if (!first) exp_q.push_back(IDLE_J);
            add_packet(cpb, 8'hC3, 1'b1, d);
        end
        repeat (4) exp_q.push_back(IDLE_J);
    endtask

    task automatic drive(input int sel, input bit a, input bit n, input bit h, input logic [7:0] d);
        if (sel == 1) begin
            ack1 = a; nack1 = n; hr1 = h; data1 = d;
        end else begin
            ack4 = a; nack4 = n; hr4 = h; data4 = d;
        end
    endtask

    function automatic logic [2:0] sample(input int sel);
        return (sel == 1) ? {busy1, dp1, dm1} : {busy4, dp4, dm4};
    endfunction

    // Request sampled at edge k; cap[0] is the state after edge k+1
    task automatic fire_and_capture(input int sel, input bit a, input bit n, input bit h,
                                    input logic [7:0] d, input int ncap);
        @(negedge clk);
        drive(sel, a, n, h, d);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 1'b0, 8'h00);
        cap.delete();
        repeat (ncap) begin
            @(negedge clk);
            cap.push_back(sample(sel));
        end
    endtask

    task automatic check_stream(input string name);
        int first_bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (first_bad < 0 && (i >= cap.size() || cap[i] !== exp_q[i])) first_bad = i;
        total++;
        if (first_bad >= 0) begin
            bad++;
            $display("FAIL %s: cycle %0d got %b want %b", name, first_bad,
                     (first_bad < cap.size()) ? cap[first_bad] : 3'bxxx, exp_q[first_bad]);
        end
    endtask

    task automatic run_req(input int cpb, input bit a, input bit n, input bit h,
                           input logic [7:0] d, input string name);
        build_expected(cpb, a, n, h, d);
        fire_and_capture(cpb, a, n, h, d, exp_q.size());
        check_stream(name);
    endtask

    function automatic int count_busy();
        int c = 0;
        foreach (cap[i]) if (cap[i][2]) c++;
        return c;
    endfunction

    function automatic int count_pkts();
        int c = 0;
        bit prev = 1'b0;
        foreach (cap[i]) begin
            if (cap[i][2] && !prev) c++;
            prev = cap[i][2];
        end
        return c;
    endfunction

    // NRZI decode and destuff of a CLKS_PER_BIT=1 capture, stopping at the first SE0
    task automatic decode_cpb1(output int nbits, output logic [39:0] payload, output int nstuff,
                               output bit stuff_ok, output int first_stuff);
        bit prev_j = 1'b1;
        bit done = 1'b0;
        bit cur_j;
        bit b;
        int ones = 0;
        nbits = 0; payload = '0; nstuff = 0; stuff_ok = 1'b1; first_stuff = -1;
        foreach (cap[i]) begin
            if (!done && cap[i][2]) begin
                if (cap[i][1:0] == 2'b00) begin
                    done = 1'b1;
                end else begin
                    cur_j  = cap[i][1];
                    b      = (cur_j == prev_j);
                    prev_j = cur_j;
                    if (ones == 6) begin
                        if (first_stuff < 0) first_stuff = nbits;
                        nstuff++;
                        if (b) stuff_ok = 1'b0;
                        ones = 0;
                    end else begin
                        if (nbits < 40) payload[nbits] = b;
                        nbits++;
                        ones = b ? ones + 1 : 0;
                    end
                end
            end
        end
    endtask

    initial begin
        int         nbits, nstuff, first_stuff, last_se0, jcnt, se0cnt, nonidle;
        bit         stuff_ok;
        logic [39:0] payload;
        int         sel, mask;
        logic [7:0] d;

        vecs[0] = '{4, 1'b1, 1'b0, 1'b0, 8'h00, 76, 1};
        vecs[1] = '{4, 1'b0, 1'b1, 1'b0, 8'h00, 76, 1};
        vecs[2] = '{4, 1'b1, 1'b1, 1'b0, 8'h00, 152, 2};
        vecs[3] = '{1, 1'b0, 1'b0, 1'b1, 8'hFF, BUSY_FF, 1};
        vecs[4] = '{1, 1'b1, 1'b1, 1'b1, 8'hFF, BUSY_ALL, 3};
        vecs[5] = '{1, 1'b1, 1'b0, 1'b0, 8'h00, 19, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dut4", int'(sample(4)), int'(IDLE_J));
        check("reset_dut1", int'(sample(1)), int'(IDLE_J));
        rst4 = 1'b0;
        rst1 = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_req(vecs[i].cpb, vecs[i].a, vecs[i].n, vecs[i].h, vecs[i].d, $sformatf("vec%0d_stream", i));
            check($sformatf("vec%0d_busy", i), count_busy(), vecs[i].exp_busy);
            check($sformatf("vec%0d_pkts", i), count_pkts(), vecs[i].exp_pkts);
        end

        run_req(4, 1'b1, 1'b0, 1'b0, 8'h00, "ack_detail_stream");
        check("ack_load_j", int'(cap[0]), int'(IDLE_J));
        check("ack_first_k", int'(cap[1]), int'(BUSY_K));
        se0cnt = 0; last_se0 = -1;
        foreach (cap[i]) if (cap[i] == BUSY_SE0) begin se0cnt++; last_se0 = i; end
        check("ack_se0_cycles", se0cnt, 8);
        jcnt = 0;
        for (int i = last_se0 + 1; i >= 1 && i < cap.size(); i++) if (cap[i] == BUSY_J) jcnt++;
        check("ack_eop_j_cycles", jcnt, 4);

        run_req(1, 1'b0, 1'b0, 1'b1, 8'hFF, "data_ff_stream");
        decode_cpb1(nbits, payload, nstuff, stuff_ok, first_stuff);
        check("data_ff_nbits", nbits, NBITS_FF);
        check("data_ff_sync", int'(payload[7:0]), 'h80);
        check("data_ff_pid", int'(payload[15:8]), 'hC3);
        check("data_ff_byte", int'(payload[23:16]), 'hFF);
        check("data_ff_nstuff", nstuff, STUFF_FF);
        check("data_ff_stuff_zero", int'(stuff_ok), 1);
        check("data_ff_stuff_pos", first_stuff, 20);
`ifdef TX_CRC16_EN
        check("data_ff_crc", int'(payload[39:24]), int'(crc16_model(8'hFF)));
`endif

        fire_and_capture(1, 1'b0, 1'b0, 1'b1, 8'hFF, 8);
        rst1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midpkt_reset_%0d", i), int'(sample(1)), int'(IDLE_J));
        end
        rst1 = 1'b0;
        nonidle = 0;
        repeat (6) begin
            @(negedge clk);
            if (sample(1) != IDLE_J) nonidle++;
        end
        check("post_reset_no_eop", nonidle, 0);
        run_req(1, 1'b1, 1'b0, 1'b0, 8'h00, "ack_after_reset");

        exp_q.delete();
        add_packet(4, 8'hD2, 1'b0, 8'h00);
        exp_q.push_back(IDLE_J);
        add_packet(4, 8'hC3, 1'b1, 8'h11);
        repeat (4) exp_q.push_back(IDLE_J);
        fork
            fire_and_capture(4, 1'b1, 1'b0, 1'b0, 8'h00, exp_q.size());
            begin
                repeat (10) @(negedge clk);
                hr4 = 1'b1; data4 = 8'h11;
                @(negedge clk);
                hr4 = 1'b0; data4 = 8'h00;
                repeat (20) @(negedge clk);
                hr4 = 1'b1; data4 = 8'h22;
                @(negedge clk);
                hr4 = 1'b0; data4 = 8'h00;
            end
        join
        check_stream("repeat_hr_stream");
        check("repeat_hr_pkts", count_pkts(), 2);

        for (int it = 0; it < 16; it++) begin
            sel  = (it % 4 == 3) ? 4 : 1;
            mask = $urandom_range(1, 7);
            d    = 8'($urandom);
            run_req(sel, mask[1], mask[0], mask[2], d, $sformatf("random%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
